// File: rtl/simd_decode_pkg.sv
// Shared types and field positions for the SIMD decode / operand-read stage.
package simd_decode_pkg;

    localparam int NUM_VREGS = 32;

    // Instruction field positions (LSB of each field)
    localparam int OPC_LSB = 26;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 11;
    localparam int WID_LSB = 9;

    typedef enum logic [5:0] {
        OPC_NOP    = 6'd0,
        OPC_VADD   = 6'd1,
        OPC_VSUB   = 6'd2,
        OPC_VMUL   = 6'd3,
        OPC_VAND   = 6'd4,
        OPC_VOR    = 6'd5,
        OPC_VXOR   = 6'd6,
        OPC_VSPLAT = 6'd7,
        OPC_HALT   = 6'd63
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_MUL    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_PASS_A = 4'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10,
        W64 = 2'b11
    } width_t;

    // Sign-extend a 16-bit immediate, truncate it to one lane and fill a
    // 64-bit chunk with copies of that lane. VLEN is a multiple of 64, so the
    // full vector is this chunk repeated.
    function automatic logic [63:0] splat64(input logic [15:0] imm, input width_t w);
        logic [63:0] r;
        case (w)
            W8:      r = {8{imm[7:0]}};
            W16:     r = {4{imm}};
            W32:     r = {2{{16{imm[15]}}, imm}};
            default: r = {{48{imm[15]}}, imm};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/simd_decode_vregfile.sv
// 32 x VLEN vector register file: two asynchronous read ports, one write
// port, synchronous reset. v0 reads as zero and ignores writes. A read of the
// register being written this cycle returns the write data.
module simd_decode_vregfile
    import simd_decode_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra_addr,
    output logic [VLEN-1:0] ra_data,
    input  logic [4:0]      rb_addr,
    output logic [VLEN-1:0] rb_data,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [VLEN-1:0] wdata
);

    logic [VLEN-1:0] regs [NUM_VREGS];

    // Storage: cleared on reset, v0 never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port A with v0 forced to zero and same-cycle write bypass
    always_comb begin
        ra_data = regs[ra_addr];
        if (ra_addr == 5'd0) begin
            ra_data = '0;
        end else if (we && waddr == ra_addr) begin
            ra_data = wdata;
        end
    end

    // Read port B with v0 forced to zero and same-cycle write bypass
    always_comb begin
        rb_data = regs[rb_addr];
        if (rb_addr == 5'd0) begin
            rb_data = '0;
        end else if (we && waddr == rb_addr) begin
            rb_data = wdata;
        end
    end

endmodule

// File: rtl/simd_decode.sv
// SIMD decode / operand-read stage: decodes fetched words, reads operands,
// tracks in-flight destination registers and issues one registered micro-op
// per cycle to execute.
//
// Handshakes: both interfaces use valid/ready. A transfer happens on a rising
// edge where valid && ready. A producer holding valid keeps its payload stable
// until the transfer; ready may depend combinationally on the other side.
module simd_decode
    import simd_decode_pkg::*;
#(
    parameter int VLEN   = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid_i,
    input  logic [31:0]       if_instr_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              if_ready_o,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [3:0]        ex_op_o,
    output logic [1:0]        ex_width_o,
    output logic [4:0]        ex_rd_o,
    output logic [VLEN-1:0]   ex_a_o,
    output logic [VLEN-1:0]   ex_b_o,
    output logic [ADDR_W-1:0] ex_pc_o,
    input  logic              wb_en_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [VLEN-1:0]   wb_data_i,
    output logic              halted_o,
    output logic              illegal_o
);

    logic [5:0]           opc;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    width_t               width;
    logic [15:0]          imm;
    alu_op_t              alu_op;
    logic                 is_alu;
    logic                 is_splat;
    logic                 is_halt;
    logic                 is_illegal;
    logic                 is_write;
    logic                 hazard;
    logic                 accept;
    logic                 issue;
    logic [NUM_VREGS-1:0] pending;
    logic [NUM_VREGS-1:0] wb_clr;
    logic [NUM_VREGS-1:0] pend_eff;
    logic [NUM_VREGS-1:0] pend_next;
    logic [VLEN-1:0]      rdata_a;
    logic [VLEN-1:0]      rdata_b;
    logic [VLEN-1:0]      splat_vec;

    // Field extraction and opcode classification. For VSPLAT the width field
    // shares bits [10:9] with the immediate.
    always_comb begin
        opc        = if_instr_i[OPC_LSB +: 6];
        rd         = if_instr_i[RD_LSB  +: 5];
        rs1        = if_instr_i[RS1_LSB +: 5];
        rs2        = if_instr_i[RS2_LSB +: 5];
        width      = width_t'(if_instr_i[WID_LSB +: 2]);
        imm        = if_instr_i[15:0];
        alu_op     = ALU_ADD;
        is_alu     = 1'b0;
        is_splat   = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opc)
            OPC_NOP:    ;
            OPC_VADD:   begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OPC_VSUB:   begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OPC_VMUL:   begin is_alu = 1'b1; alu_op = ALU_MUL; end
            OPC_VAND:   begin is_alu = 1'b1; alu_op = ALU_AND; end
            OPC_VOR:    begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OPC_VXOR:   begin is_alu = 1'b1; alu_op = ALU_XOR; end
            OPC_VSPLAT: begin is_splat = 1'b1; alu_op = ALU_PASS_A; end
            OPC_HALT:   is_halt = 1'b1;
            default:    is_illegal = 1'b1;
        endcase
        is_write = is_alu || is_splat;
    end

    // Hazard check: a register retiring this cycle no longer counts as busy
    always_comb begin
        wb_clr   = wb_en_i ? (NUM_VREGS'(1) << wb_rd_i) : '0;
        pend_eff = pending & ~wb_clr;
        hazard   = (is_alu && (pend_eff[rs1] || pend_eff[rs2])) ||
                   (is_write && pend_eff[rd]);
    end

    assign if_ready_o = !halted_o && !hazard && (!ex_valid_o || ex_ready_i);
    assign accept     = if_valid_i && if_ready_o;
    assign issue      = accept && is_write;
    assign splat_vec  = {(VLEN/64){splat64(imm, width)}};

    // Next scoreboard: retire first, then mark the new destination so a
    // same-cycle set and clear on one register leaves it busy
    always_comb begin
        pend_next = pending & ~wb_clr;
        if (issue) begin
            pend_next[rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pend_next;
        end
    end

    simd_decode_vregfile #(.VLEN(VLEN)) u_vregfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rs1),
        .ra_data (rdata_a),
        .rb_addr (rs2),
        .rb_data (rdata_b),
        .we      (wb_en_i),
        .waddr   (wb_rd_i),
        .wdata   (wb_data_i)
    );

    // Micro-op output register: load on issue, hold while stalled, drop
    // valid after a handshake with nothing new behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_o <= 1'b0;
            ex_op_o    <= '0;
            ex_width_o <= '0;
            ex_rd_o    <= '0;
            ex_a_o     <= '0;
            ex_b_o     <= '0;
            ex_pc_o    <= '0;
        end else if (issue) begin
            ex_valid_o <= 1'b1;
            ex_op_o    <= alu_op;
            ex_width_o <= width;
            ex_rd_o    <= rd;
            ex_a_o     <= is_splat ? splat_vec : rdata_a;
            ex_b_o     <= is_splat ? '0 : rdata_b;
            ex_pc_o    <= if_pc_i;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    // Sticky halt flag and one-cycle illegal-opcode pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_o  <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            if (accept && is_halt) begin
                halted_o <= 1'b1;
            end
            illegal_o <= accept && is_illegal;
        end
    end

endmodule

// File: tb/tb_simd_decode.sv
// Bench for simd_decode: decode table, hand-written stall/halt sequences and
// a randomized run against a register-level reference model.
module tb_simd_decode;

    localparam int VLEN   = 128;
    localparam int ADDR_W = 32;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              if_valid = 1'b0;
    logic [31:0]       if_instr = '0;
    logic [ADDR_W-1:0] if_pc = '0;
    logic              if_ready;
    logic              ex_valid;
    logic              ex_ready = 1'b1;
    logic [3:0]        ex_op;
    logic [1:0]        ex_width;
    logic [4:0]        ex_rd;
    logic [VLEN-1:0]   ex_a;
    logic [VLEN-1:0]   ex_b;
    logic [ADDR_W-1:0] ex_pc;
    logic              wb_en = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [VLEN-1:0]   wb_data = '0;
    logic              halted;
    logic              illegal;

    always #5 clk = ~clk;

    simd_decode #(.VLEN(VLEN), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid_i (if_valid),
        .if_instr_i (if_instr),
        .if_pc_i    (if_pc),
        .if_ready_o (if_ready),
        .ex_valid_o (ex_valid),
        .ex_ready_i (ex_ready),
        .ex_op_o    (ex_op),
        .ex_width_o (ex_width),
        .ex_rd_o    (ex_rd),
        .ex_a_o     (ex_a),
        .ex_b_o     (ex_b),
        .ex_pc_o    (ex_pc),
        .wb_en_i    (wb_en),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .halted_o   (halted),
        .illegal_o  (illegal)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [3:0]        op;
        logic [1:0]        width;
        logic [4:0]        rd;
        logic [VLEN-1:0]   a;
        logic [VLEN-1:0]   b;
        logic [ADDR_W-1:0] pc;
    } uop_t;

    uop_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        if_instr = '0;
        wb_en    = 1'b0;
        ex_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [4:0] r, input logic [VLEN-1:0] d);
        wb_en   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        step();
        wb_en   = 1'b0;
    endtask

    function automatic logic [31:0] mk(input int opc, input int rd, input int rs1, input int rs2, input int w);
        return {6'(opc), 5'(rd), 5'(rs1), 5'(rs2), 2'(w), 9'd0};
    endfunction

    function automatic logic [31:0] mk_splat(input int rd, input logic [15:0] imm);
        return {6'd7, 5'(rd), 5'd0, imm};
    endfunction

    // Reference splat: sign-extend imm, keep one lane, repeat the lane bit pattern
    function automatic logic [VLEN-1:0] ref_splat(input logic [15:0] imm, input logic [1:0] w);
        logic [VLEN-1:0] r;
        logic [63:0]     e;
        int              lw;
        lw = 8 << w;
        e  = 64'(longint'($signed(imm)));
        for (int b = 0; b < VLEN; b++) begin
            r[b] = e[b % lw];
        end
        return r;
    endfunction

    // ---------------- decode table ----------------
    typedef struct {
        logic [31:0]     instr;
        logic            issue;
        logic [3:0]      op;
        logic [1:0]      width;
        logic [4:0]      rd;
        logic [VLEN-1:0] a;
        logic [VLEN-1:0] b;
        logic            ill;
    } vec_t;

    vec_t vecs[12];

    // ---------------- reference model state ----------------
    logic [VLEN-1:0] m_regs [32];
    bit              m_pend [32];
    bit              m_valid;
    bit              m_ill;

    initial begin
        logic [31:0] ins;
        int          opc;
        int          cand[$];
        uop_t        u;
        bit          busy;
        bit          exp_rdy;
        bit          acc;

        vecs[0]  = '{mk(1, 3, 1, 2, 0), 1'b1, 4'd0, 2'd0, 5'd3, 128'd5, 128'd7, 1'b0};
        vecs[1]  = '{mk(2, 4, 1, 2, 1), 1'b1, 4'd1, 2'd1, 5'd4, 128'd5, 128'd7, 1'b0};
        vecs[2]  = '{mk(3, 5, 2, 1, 2), 1'b1, 4'd2, 2'd2, 5'd5, 128'd7, 128'd5, 1'b0};
        vecs[3]  = '{mk(4, 6, 1, 2, 3), 1'b1, 4'd3, 2'd3, 5'd6, 128'd5, 128'd7, 1'b0};
        vecs[4]  = '{mk(5, 7, 1, 0, 0), 1'b1, 4'd4, 2'd0, 5'd7, 128'd5, 128'd0, 1'b0};
        vecs[5]  = '{mk(6, 8, 2, 2, 1), 1'b1, 4'd5, 2'd1, 5'd8, 128'd7, 128'd7, 1'b0};
        vecs[6]  = '{mk_splat(5, 16'hFAFE), 1'b1, 4'd6, 2'd1, 5'd5, {8{16'hFAFE}}, 128'd0, 1'b0};
        vecs[7]  = '{mk_splat(5, 16'h8600), 1'b1, 4'd6, 2'd3, 5'd5, {2{64'hFFFF_FFFF_FFFF_8600}}, 128'd0, 1'b0};
        vecs[8]  = '{mk_splat(9, 16'h0181), 1'b1, 4'd6, 2'd0, 5'd9, {16{8'h81}}, 128'd0, 1'b0};
        vecs[9]  = '{mk_splat(9, 16'h8401), 1'b1, 4'd6, 2'd2, 5'd9, {4{32'hFFFF_8401}}, 128'd0, 1'b0};
        vecs[10] = '{mk(0, 3, 1, 2, 0), 1'b0, 4'd0, 2'd0, 5'd0, 128'd0, 128'd0, 1'b0};
        vecs[11] = '{mk(9, 3, 1, 2, 0), 1'b0, 4'd0, 2'd0, 5'd0, 128'd0, 128'd0, 1'b1};

        // ---- reset state ----
        do_reset();
        check("rst_ex_valid", 128'(ex_valid), 128'd0);
        check("rst_halted",   128'(halted),   128'd0);
        check("rst_illegal",  128'(illegal),  128'd0);
        check("rst_ex_a",     ex_a,           128'd0);
        check("rst_ex_b",     ex_b,           128'd0);
        check("rst_ex_pc",    128'(ex_pc),    128'd0);
        check("rst_ex_rd",    128'(ex_rd),    128'd0);
        check("rst_if_ready", 128'(if_ready), 128'd1);

        // ---- decode table ----
        for (int i = 0; i < 12; i++) begin
            do_reset();
            preload(5'd1, 128'd5);
            preload(5'd2, 128'd7);
            if_valid = 1'b1;
            if_instr = vecs[i].instr;
            if_pc    = 32'h100 + 32'(4 * i);
            #1;
            check($sformatf("tbl%0d_if_ready", i), 128'(if_ready), 128'd1);
            step();
            if_valid = 1'b0;
            check($sformatf("tbl%0d_ex_valid", i), 128'(ex_valid), 128'(vecs[i].issue));
            check($sformatf("tbl%0d_illegal", i), 128'(illegal), 128'(vecs[i].ill));
            if (vecs[i].issue) begin
                check($sformatf("tbl%0d_op", i),    128'(ex_op),    128'(vecs[i].op));
                check($sformatf("tbl%0d_width", i), 128'(ex_width), 128'(vecs[i].width));
                check($sformatf("tbl%0d_rd", i),    128'(ex_rd),    128'(vecs[i].rd));
                check($sformatf("tbl%0d_a", i),     ex_a,           vecs[i].a);
                check($sformatf("tbl%0d_b", i),     ex_b,           vecs[i].b);
                check($sformatf("tbl%0d_pc", i),    128'(ex_pc),    128'(32'h100 + 32'(4 * i)));
            end
        end

        // ---- RAW stall released by same-cycle writeback ----
        do_reset();
        preload(5'd1, 128'd5);
        preload(5'd2, 128'd7);
        if_valid = 1'b1;
        if_instr = mk(1, 3, 1, 2, 2);
        if_pc    = 32'h200;
        step();
        check("seq1_ex_valid", 128'(ex_valid), 128'd1);
        check("seq1_a", ex_a, 128'd5);
        check("seq1_b", ex_b, 128'd7);
        check("seq1_rd", 128'(ex_rd), 128'd3);
        if_instr = mk(1, 4, 3, 3, 2);
        if_pc    = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("seq2_stall%0d", c), 128'(if_ready), 128'd0);
            step();
        end
        check("seq2_valid_drop", 128'(ex_valid), 128'd0);
        wb_en   = 1'b1;
        wb_rd   = 5'd3;
        wb_data = 128'd9;
        #1;
        check("seq2_release", 128'(if_ready), 128'd1);
        step();
        wb_en = 1'b0;
        check("seq2_ex_valid", 128'(ex_valid), 128'd1);
        check("seq2_a", ex_a, 128'd9);
        check("seq2_b", ex_b, 128'd9);
        check("seq2_rd", 128'(ex_rd), 128'd4);

        // ---- downstream backpressure ----
        ex_ready = 1'b0;
        if_instr = mk(2, 6, 1, 2, 0);
        if_pc    = 32'h208;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("seq3_if_ready%0d", c), 128'(if_ready), 128'd0);
            check($sformatf("seq3_hold_valid%0d", c), 128'(ex_valid), 128'd1);
            check($sformatf("seq3_hold_rd%0d", c), 128'(ex_rd), 128'd4);
            check($sformatf("seq3_hold_a%0d", c), ex_a, 128'd9);
            step();
        end
        ex_ready = 1'b1;
        #1;
        check("seq3_if_ready_go", 128'(if_ready), 128'd1);
        step();
        if_valid = 1'b0;
        check("seq3_b2b_valid", 128'(ex_valid), 128'd1);
        check("seq3_b2b_rd", 128'(ex_rd), 128'd6);
        check("seq3_b2b_op", 128'(ex_op), 128'd1);
        check("seq3_b2b_pc", 128'(ex_pc), 128'h208);

        // ---- illegal pulse, halt, reset ----
        do_reset();
        if_valid = 1'b1;
        if_instr = mk(9, 1, 1, 1, 0);
        step();
        if_valid = 1'b0;
        check("seq5_illegal_pulse", 128'(illegal), 128'd1);
        check("seq5_illegal_noissue", 128'(ex_valid), 128'd0);
        step();
        check("seq5_illegal_clear", 128'(illegal), 128'd0);
        if_valid = 1'b1;
        if_instr = mk(63, 0, 0, 0, 0);
        step();
        check("seq5_halted", 128'(halted), 128'd1);
        if_instr = mk(1, 3, 1, 2, 0);
        wb_en    = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 128'h55;
        #1;
        check("seq5_halt_ready", 128'(if_ready), 128'd0);
        step();
        wb_en    = 1'b0;
        if_valid = 1'b0;
        check("seq5_halt_sticky", 128'(halted), 128'd1);
        check("seq5_halt_noissue", 128'(ex_valid), 128'd0);
        do_reset();
        check("seq5_reset_halt", 128'(halted), 128'd0);
        check("seq5_reset_ready", 128'(if_ready), 128'd1);

        // ---- v0 destination is never busy ----
        preload(5'd2, 128'd7);
        if_valid = 1'b1;
        if_instr = mk(1, 0, 2, 2, 0);
        step();
        check("seq6_v0_issue", 128'(ex_valid), 128'd1);
        check("seq6_v0_rd", 128'(ex_rd), 128'd0);
        if_instr = mk(5, 7, 0, 2, 0);
        #1;
        check("seq6_no_stall", 128'(if_ready), 128'd1);
        step();
        if_valid = 1'b0;
        check("seq6_a_zero", ex_a, 128'd0);
        check("seq6_b", ex_b, 128'd7);
        check("seq6_op", 128'(ex_op), 128'd4);

        // ---- randomized run against the reference model ----
        do_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_valid = 1'b0;
        m_ill   = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_ex_valid", 128'(ex_valid), 128'(m_valid));
            check("rnd_illegal", 128'(illegal), 128'(m_ill));

            case ($urandom_range(0, 9))
                0:       opc = 0;
                1:       opc = 9;
                default: opc = $urandom_range(1, 7);
            endcase
            ins      = {6'(opc), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 11'($urandom)};
            if_valid = ($urandom_range(0, 3) != 0);
            if_instr = ins;
            if_pc    = $urandom;
            ex_ready = ($urandom_range(0, 2) != 0);
            cand.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
            wb_en = ($urandom_range(0, 2) == 0);
            if (cand.size() > 0 && $urandom_range(0, 3) != 0)
                wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                wb_rd = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom, $urandom, $urandom};
            #1;

            // Model: a register is busy if in flight and not retiring now
            busy = 1'b0;
            if (opc >= 1 && opc <= 6) begin
                if (m_pend[ins[20:16]] && !(wb_en && wb_rd == ins[20:16])) busy = 1'b1;
                if (m_pend[ins[15:11]] && !(wb_en && wb_rd == ins[15:11])) busy = 1'b1;
            end
            if (opc >= 1 && opc <= 7) begin
                if (m_pend[ins[25:21]] && !(wb_en && wb_rd == ins[25:21])) busy = 1'b1;
            end
            exp_rdy = !busy && (!m_valid || ex_ready);
            check("rnd_if_ready", 128'(if_ready), 128'(exp_rdy));

            if (m_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_q_nonempty", 128'd0, 128'd1);
                end else begin
                    u = exp_q.pop_front();
                    check("rnd_op",    128'(ex_op),    128'(u.op));
                    check("rnd_width", 128'(ex_width), 128'(u.width));
                    check("rnd_rd",    128'(ex_rd),    128'(u.rd));
                    check("rnd_a",     ex_a,           u.a);
                    check("rnd_b",     ex_b,           u.b);
                    check("rnd_pc",    128'(ex_pc),    128'(u.pc));
                end
            end

            acc   = if_valid && exp_rdy;
            m_ill = acc && !(opc <= 7);
            if (acc && opc >= 1 && opc <= 7) begin
                u.width = ins[10:9];
                u.rd    = ins[25:21];
                u.pc    = if_pc;
                if (opc == 7) begin
                    u.op = 4'd6;
                    u.a  = ref_splat(ins[15:0], ins[10:9]);
                    u.b  = '0;
                end else begin
                    u.op = 4'(opc - 1);
                    u.a  = (ins[20:16] == 0) ? '0 :
                           (wb_en && wb_rd == ins[20:16]) ? wb_data : m_regs[ins[20:16]];
                    u.b  = (ins[15:11] == 0) ? '0 :
                           (wb_en && wb_rd == ins[15:11]) ? wb_data : m_regs[ins[15:11]];
                end
                exp_q.push_back(u);
                m_valid = 1'b1;
            end else if (m_valid && ex_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 0) begin
                m_regs[wb_rd] = wb_data;
                m_pend[wb_rd] = 1'b0;
            end
            if (acc && opc >= 1 && opc <= 7 && ins[25:21] != 0) begin
                m_pend[ins[25:21]] = 1'b1;
            end
            step();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
